el2_pmp_csr: RTL and testbench
==============================

Name: el2_pmp_csr

Overview:
- PMP configuration register file: the producer side of the pmpcfg/pmpaddr interface that the PMP checker consumes.
- Sits in the dec/tlu CSR path. It decodes CSR reads and writes to pmpcfg0..15 and pmpaddr0..63, applies WARL and lock rules, and holds the architectural state.
- Drives `pmp_pmpcfg` and `pmp_pmpaddr` straight into the checker.
- Issues a registered change pulse so the fetch and LSU paths can flush stale permission decisions.

Parameters:
- PMP_GRANULARITY, 0, NAPOT/TOR granule G (0 = 4 B, 1 = 8 B, ...); must equal the checker's value.
- pt.PMP_ENTRIES, from el2_param.vh, number of implemented entries: 0, 16 or 64.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- scan_mode  in  1  scan mode; no functional effect, reserved for clock-gate override
- csr_wr_en  in  1  CSR write strobe, one write per asserted cycle
- csr_wr_addr  in  12  CSR address of the write
- csr_wr_data  in  32  final write value; set/clear already resolved upstream
- csr_rd_addr  in  12  CSR address of the read; combinational read port
- csr_rd_hit  out  1  csr_rd_addr is a PMP CSR (0x3A0–0x3EF)
- csr_rd_data  out  32  read value; 0 when csr_rd_hit=0
- pmp_pmpcfg  out  el2_pmp_cfg_pkt_t[pt.PMP_ENTRIES]  per-entry config
- pmp_pmpaddr  out  32×[pt.PMP_ENTRIES]  per-entry address, stored value
- pmp_cfg_changed  out  1  one-cycle pulse, the cycle after any write that changed state

Behaviour:
- Reset (async, rst_l=0):
  - All cfg fields 0: mode OFF, lock 0, X/W/R 0.
  - All pmpaddr = 0.
  - pmp_cfg_changed = 0.
- Address map:
  - pmpcfgN at 0x3A0+N (N = 0..15) packs entries 4N..4N+3, byte k = entry 4N+k.
  - Byte layout: [7] = L, [6:5] reserved (read 0), [4:3] = A (OFF/TOR/NA4/NAPOT), [2] = X, [1] = W, [0] = R.
  - pmpaddrM at 0x3B0+M (M = 0..63).
  - Unimplemented entries (index ≥ pt.PMP_ENTRIES): csr_rd_hit=1, read 0, writes ignored.
- Writes:
  - Take effect at the next rising edge; outputs are registered.
  - Reads are combinational from current state.
  - A read and write to the same CSR in the same cycle returns the old value.
- Cfg byte write:
  - Skipped entirely if that entry's L=1. Other bytes of the same pmpcfg write still apply.
  - WARL: W=1 with R=0 is stored as W=0 and R=0; X and other bits are still written.
  - WARL: A=NA4 when PMP_GRANULARITY ≥ 1 keeps the previous A value; the remaining fields are still written.
  - Reserved bits are always stored as 0.
- pmpaddr[i] write is ignored when either holds:
  - cfg[i].L=1;
  - cfg[i+1].L=1 and cfg[i+1].A=TOR (only for i+1 < pt.PMP_ENTRIES).
- pmpaddr is stored in full 32 bits; the granularity effect is applied on read only:
  - G ≥ 2 and A=NAPOT: bits [G-2:0] read as 1.
  - G ≥ 1 and A ∈ {OFF, TOR}: bits [G-1:0] read as 0.
  - G = 0: read = stored value.
- Lock is sticky: L clears only on reset. A write of L=0 to a locked entry has no effect.
- pmp_cfg_changed:
  - Asserted the cycle after a write that modified any stored bit.
  - Not asserted for ignored or no-op writes.
  - Back-to-back changing writes give back-to-back pulses.
- Reset asserted mid-write: the write is lost and state returns to reset values immediately.
- pt.PMP_ENTRIES=0: no storage; every PMP CSR reads 0 and pmp_cfg_changed stays 0.

Decomposition:
- el2_pkg holds el2_pmp_cfg_pkt_t, the pmp mode enum (OFF/TOR/NA4/NAPOT), and the constants PMPCFG_BASE=12'h3A0 and PMPADDR_BASE=12'h3B0.
- Natural sub-module: el2_pmp_csr_entry, one per entry. It holds the cfg and addr flops and implements the lock, WARL and read-mask logic.
- The top level does address decode, byte steering, the read mux and the change pulse.

Test Plan:
- Reset then read 0x3A0 and 0x3B0 -> both 0; pmp_pmpcfg[0].mode=OFF; pmp_cfg_changed=0.
- Write 0x3A0=32'h0000_0F1F, G=0 -> entry0 NAPOT+RWX, L=0; entry1 TOR+RWX; read 0x3A0=32'h0000_0F1F; pmp_cfg_changed pulses one cycle later.
- Write 0x3A0=32'h0000_0002 (W without R) -> entry0 R=0 and W=0; read 0x3A0=0.
- Set entry1 = 8'h8F (L=1, TOR), then:
  - write 0x3B0 (pmpaddr0) = 32'h1000 -> ignored;
  - write 0x3B1 (pmpaddr1) -> ignored;
  - write 0x3A0 with L=0 -> entry1 unchanged;
  - pmp_cfg_changed stays 0 for all three.
- G=2, pmpaddr0=32'h0000_1000 with entry0 NAPOT -> read 32'h0000_1001; with entry0 TOR -> read 32'h0000_1000; pmpaddr0=32'h0000_1003 with TOR -> read 32'h0000_1000.
- pt.PMP_ENTRIES=16, write 0x3C5 (pmpaddr21) = 32'hFFFF -> csr_rd_hit=1, read 0, pmp_cfg_changed stays 0.
- Assert rst_l low mid-sequence -> all state 0 immediately.

Source files
------------

// File: rtl/el2_pmp_csr_pkg.sv
// Shared types and CSR address constants for the PMP configuration register file.
// Entry config packs into one pmpcfg byte: {L, rsvd[1:0], A[1:0], X, W, R}.
package el2_pmp_csr_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } el2_pmp_mode_t;

  typedef struct packed {
    logic          lock;
    logic [1:0]    rsvd;
    el2_pmp_mode_t mode;
    logic          execute;
    logic          write;
    logic          read;
  } el2_pmp_cfg_pkt_t;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;
  localparam logic [11:0] PMPADDR_LAST = 12'h3EF;

  function automatic logic pmp_is_cfg(input logic [11:0] a);
    return (a >= PMPCFG_BASE) && (a < PMPADDR_BASE);
  endfunction

  function automatic logic pmp_is_addr(input logic [11:0] a);
    return (a >= PMPADDR_BASE) && (a <= PMPADDR_LAST);
  endfunction

  function automatic logic [5:0] pmp_addr_idx(input logic [11:0] a);
    return 6'(a - PMPADDR_BASE);
  endfunction

endpackage

// File: rtl/el2_pmp_csr_if.sv
// CSR access bus between dec/tlu (master) and the PMP register file (slave).
interface el2_pmp_csr_if;
  logic        csr_wr_en;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic [11:0] csr_rd_addr;
  logic        csr_rd_hit;
  logic [31:0] csr_rd_data;

  modport master (
    output csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
    input  csr_rd_hit, csr_rd_data
  );

  modport slave (
    input  csr_wr_en, csr_wr_addr, csr_wr_data, csr_rd_addr,
    output csr_rd_hit, csr_rd_data
  );
endinterface

// File: rtl/el2_pmp_csr_entry.sv
// One PMP entry: cfg byte and pmpaddr storage with lock, WARL legalisation
// and granularity masking of the pmpaddr read view.
module el2_pmp_csr_entry
  import el2_pmp_csr_pkg::*;
#(
  parameter int PMP_GRANULARITY = 0
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             cfg_we,
  input  logic [7:0]       cfg_wdata,
  input  logic             addr_we,
  input  logic [31:0]      addr_wdata,
  input  logic             next_tor_locked,
  output el2_pmp_cfg_pkt_t cfg,
  output logic [31:0]      addr,
  output logic [31:0]      addr_rd,
  output logic             changed
);

  localparam int          NAPOT_W    = (PMP_GRANULARITY >= 2) ? PMP_GRANULARITY - 1 : 0;
  localparam logic [31:0] NAPOT_ONES = (32'd1 << NAPOT_W) - 32'd1;
  localparam logic [31:0] TOR_ZEROS  = (32'd1 << PMP_GRANULARITY) - 32'd1;

  el2_pmp_cfg_pkt_t cfg_q, cfg_d;
  logic [31:0]      addr_q, addr_d;

  function automatic el2_pmp_cfg_pkt_t warl_cfg(input el2_pmp_cfg_pkt_t old_cfg,
                                                 input logic [7:0] wr);
    el2_pmp_cfg_pkt_t nc;
    nc      = el2_pmp_cfg_pkt_t'(wr);
    nc.rsvd = 2'b00;
    if (nc.write && !nc.read) nc.write = 1'b0;
    // NA4 is not representable once the granule exceeds 4 bytes.
    if ((PMP_GRANULARITY >= 1) && (nc.mode == PMP_NA4)) nc.mode = old_cfg.mode;
    return nc;
  endfunction

  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    if (cfg_we && !cfg_q.lock) cfg_d = warl_cfg(cfg_q, cfg_wdata);
    if (addr_we && !cfg_q.lock && !next_tor_locked) addr_d = addr_wdata;
  end

  assign changed = (cfg_d != cfg_q) || (addr_d != addr_q);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cfg_q  <= '0;
      addr_q <= '0;
    end else begin
      cfg_q  <= cfg_d;
      addr_q <= addr_d;
    end
  end

  always_comb begin
    addr_rd = addr_q;
    if (cfg_q.mode == PMP_NAPOT) addr_rd = addr_q | NAPOT_ONES;
    else if (cfg_q.mode == PMP_OFF || cfg_q.mode == PMP_TOR) addr_rd = addr_q & ~TOR_ZEROS;
  end

  assign cfg  = cfg_q;
  assign addr = addr_q;

endmodule

// File: rtl/el2_pmp_csr.sv
// PMP CSR register file: decodes pmpcfg/pmpaddr accesses, steers bytes to
// the per-entry storage, muxes reads and raises a registered change pulse.
module el2_pmp_csr
  import el2_pmp_csr_pkg::*;
#(
  parameter int  PMP_GRANULARITY = 0,
  parameter int  PMP_ENTRIES     = 16,
  localparam int NE              = (PMP_ENTRIES == 0) ? 1 : PMP_ENTRIES
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             scan_mode,
  el2_pmp_csr_if.slave     csr,
  output el2_pmp_cfg_pkt_t pmp_pmpcfg  [NE],
  output logic [31:0]      pmp_pmpaddr [NE],
  output logic             pmp_cfg_changed
);

  logic        unused_scan_mode;
  logic        wr_is_cfg, wr_is_addr, rd_is_cfg, rd_is_addr;
  logic [3:0]  wr_cfg_idx, rd_cfg_idx;
  logic [5:0]  wr_addr_idx, rd_addr_idx;
  logic [31:0] addr_rd_vec [NE];
  logic [NE-1:0] chg_vec;
  logic        cfg_changed_d, cfg_changed_q;
  logic [31:0] rd_data;

  assign unused_scan_mode = scan_mode;

  assign wr_is_cfg   = pmp_is_cfg(csr.csr_wr_addr);
  assign wr_is_addr  = pmp_is_addr(csr.csr_wr_addr);
  assign wr_cfg_idx  = csr.csr_wr_addr[3:0];
  assign wr_addr_idx = pmp_addr_idx(csr.csr_wr_addr);
  assign rd_is_cfg   = pmp_is_cfg(csr.csr_rd_addr);
  assign rd_is_addr  = pmp_is_addr(csr.csr_rd_addr);
  assign rd_cfg_idx  = csr.csr_rd_addr[3:0];
  assign rd_addr_idx = pmp_addr_idx(csr.csr_rd_addr);

  if (PMP_ENTRIES == 0) begin : g_none
    assign pmp_pmpcfg[0]  = '0;
    assign pmp_pmpaddr[0] = '0;
    assign addr_rd_vec[0] = '0;
    assign chg_vec        = '0;
  end else begin : g_ent
    for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_e
      logic nxt_lock;
      // A locked TOR entry also freezes the pmpaddr below it (its base).
      if (i + 1 < PMP_ENTRIES) begin : g_nxt
        assign nxt_lock = pmp_pmpcfg[i+1].lock && (pmp_pmpcfg[i+1].mode == PMP_TOR);
      end else begin : g_last
        assign nxt_lock = 1'b0;
      end

      el2_pmp_csr_entry #(.PMP_GRANULARITY(PMP_GRANULARITY)) u_entry (
        .clk             (clk),
        .rst_l           (rst_l),
        .cfg_we          (csr.csr_wr_en && wr_is_cfg && (wr_cfg_idx == 4'(i / 4))),
        .cfg_wdata       (csr.csr_wr_data[8*(i%4) +: 8]),
        .addr_we         (csr.csr_wr_en && wr_is_addr && (wr_addr_idx == 6'(i))),
        .addr_wdata      (csr.csr_wr_data),
        .next_tor_locked (nxt_lock),
        .cfg             (pmp_pmpcfg[i]),
        .addr            (pmp_pmpaddr[i]),
        .addr_rd         (addr_rd_vec[i]),
        .changed         (chg_vec[i])
      );
    end
  end

  assign cfg_changed_d = |chg_vec;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) cfg_changed_q <= 1'b0;
    else        cfg_changed_q <= cfg_changed_d;
  end

  assign pmp_cfg_changed = cfg_changed_q;

  // Unimplemented entries fall outside the loop and read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < PMP_ENTRIES; i++) begin
      if (rd_is_cfg && (rd_cfg_idx == 4'(i / 4))) rd_data[8*(i%4) +: 8] = pmp_pmpcfg[i];
      if (rd_is_addr && (rd_addr_idx == 6'(i))) rd_data = addr_rd_vec[i];
    end
  end

  assign csr.csr_rd_hit  = rd_is_cfg || rd_is_addr;
  assign csr.csr_rd_data = rd_data;

endmodule

// File: tb/tb_el2_pmp_csr.sv
// Bench for el2_pmp_csr: G=0 and G=2 instances with 16 entries plus a
// zero-entry instance, all driven with the same CSR traffic.
module tb_el2_pmp_csr;
  import el2_pmp_csr_pkg::*;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  el2_pmp_csr_if bus0 ();
  el2_pmp_csr_if bus2 ();
  el2_pmp_csr_if busz ();

  el2_pmp_cfg_pkt_t cfg_o0 [16];
  el2_pmp_cfg_pkt_t cfg_o2 [16];
  el2_pmp_cfg_pkt_t cfg_oz [1];
  logic [31:0]      addr_o0 [16];
  logic [31:0]      addr_o2 [16];
  logic [31:0]      addr_oz [1];
  logic             chg0, chg2, chgz;

  el2_pmp_csr #(.PMP_GRANULARITY(0), .PMP_ENTRIES(16)) u_g0 (
    .clk(clk), .rst_l(rst_l), .scan_mode(1'b0), .csr(bus0),
    .pmp_pmpcfg(cfg_o0), .pmp_pmpaddr(addr_o0), .pmp_cfg_changed(chg0));
  el2_pmp_csr #(.PMP_GRANULARITY(2), .PMP_ENTRIES(16)) u_g2 (
    .clk(clk), .rst_l(rst_l), .scan_mode(1'b0), .csr(bus2),
    .pmp_pmpcfg(cfg_o2), .pmp_pmpaddr(addr_o2), .pmp_cfg_changed(chg2));
  el2_pmp_csr #(.PMP_GRANULARITY(0), .PMP_ENTRIES(0)) u_z (
    .clk(clk), .rst_l(rst_l), .scan_mode(1'b0), .csr(busz),
    .pmp_pmpcfg(cfg_oz), .pmp_pmpaddr(addr_oz), .pmp_cfg_changed(chgz));

  // Reference state: index 0 models G=0, index 1 models G=2.
  logic [7:0]  mcfg  [2][16];
  logic [31:0] maddr [2][16];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int e = 0; e < 16; e++) begin
        mcfg[d][e]  = 8'h00;
        maddr[d][e] = 32'h0;
      end
  endtask

  function automatic int gran(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic in_range(input logic [11:0] a);
    return (a >= 12'h3A0) && (a <= 12'h3EF);
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [11:0] a);
    logic [31:0] r;
    int n, m, g;
    logic [1:0] md;
    r = 32'h0;
    g = gran(d);
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      n = int'(a) - 'h3A0;
      for (int k = 0; k < 4; k++)
        if (4 * n + k < 16) r = r | (32'(mcfg[d][4*n+k]) << (8 * k));
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      m = int'(a) - 'h3B0;
      if (m < 16) begin
        r  = maddr[d][m];
        md = mcfg[d][m][4:3];
        if (g >= 2 && md == 2'b11) r = r | ((32'd1 << (g - 1)) - 32'd1);
        if (g >= 1 && md <= 2'b01) r = r & ~((32'd1 << g) - 32'd1);
      end
    end
    return r;
  endfunction

  task automatic model_write(input int d, input logic [11:0] a, input logic [31:0] v,
                             output logic ch);
    int n, m, e, g;
    logic [7:0] b;
    logic locked;
    ch = 1'b0;
    g  = gran(d);
    if (a >= 12'h3A0 && a <= 12'h3AF) begin
      n = int'(a) - 'h3A0;
      for (int k = 0; k < 4; k++) begin
        e = 4 * n + k;
        if (e < 16 && !mcfg[d][e][7]) begin
          b = v[8*k +: 8] & 8'h9F;
          if (b[1:0] == 2'b10) b[1] = 1'b0;
          if (g >= 1 && b[4:3] == 2'b10) b[4:3] = mcfg[d][e][4:3];
          if (b != mcfg[d][e]) ch = 1'b1;
          mcfg[d][e] = b;
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3EF) begin
      m = int'(a) - 'h3B0;
      if (m < 16) begin
        locked = mcfg[d][m][7];
        if (m < 15 && mcfg[d][m+1][7] && mcfg[d][m+1][4:3] == 2'b01) locked = 1'b1;
        if (!locked && v != maddr[d][m]) begin
          ch = 1'b1;
          maddr[d][m] = v;
        end
      end
    end
  endtask

  task automatic drive(input logic en, input logic [11:0] wa, input logic [31:0] wd);
    bus0.csr_wr_en = en; bus0.csr_wr_addr = wa; bus0.csr_wr_data = wd;
    bus2.csr_wr_en = en; bus2.csr_wr_addr = wa; bus2.csr_wr_data = wd;
    busz.csr_wr_en = en; busz.csr_wr_addr = wa; busz.csr_wr_data = wd;
  endtask

  task automatic set_rd(input logic [11:0] a);
    bus0.csr_rd_addr = a; bus2.csr_rd_addr = a; busz.csr_rd_addr = a;
  endtask

  // Issue one write, then check the change pulse of every instance.
  task automatic wr(input logic [11:0] a, input logic [31:0] v);
    logic c0, c2;
    drive(1'b1, a, v);
    model_write(0, a, v, c0);
    model_write(1, a, v, c2);
    @(posedge clk);
    #1;
    drive(1'b0, 12'h000, 32'h0);
    chk("chg_g0", 32'(chg0), 32'(c0));
    chk("chg_g2", 32'(chg2), 32'(c2));
    chk("chg_e0", 32'(chgz), 32'h0);
  endtask

  task automatic rd_chk(input logic [11:0] a);
    set_rd(a);
    #1;
    chk("rd_g0", bus0.csr_rd_data, model_read(0, a));
    chk("rd_g2", bus2.csr_rd_data, model_read(1, a));
    chk("rd_e0", busz.csr_rd_data, 32'h0);
    chk("hit_g0", 32'(bus0.csr_rd_hit), 32'(in_range(a)));
    chk("hit_e0", 32'(busz.csr_rd_hit), 32'(in_range(a)));
  endtask

  task automatic state_chk();
    for (int e = 0; e < 16; e++) begin
      chk("cfg_out_g0", 32'(cfg_o0[e]), 32'(mcfg[0][e]));
      chk("cfg_out_g2", 32'(cfg_o2[e]), 32'(mcfg[1][e]));
      chk("addr_out_g0", addr_o0[e], maddr[0][e]);
      chk("addr_out_g2", addr_o2[e], maddr[1][e]);
    end
  endtask

  // Reset arrives while a write is on the bus; the write must be lost.
  task automatic mid_reset(input logic [31:0] v);
    drive(1'b1, 12'h3B2, v);
    #2;
    rst_l = 1'b0;
    model_clear();
    #1;
    state_chk();
    chk("rst_chg_g0", 32'(chg0), 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 12'h000, 32'h0);
    chk("rst_hold_addr2", addr_o0[2], 32'h0);
    rst_l = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    logic [11:0] a;
    logic [7:0]  b;
    drive(1'b0, 12'h000, 32'h0);
    set_rd(12'h3A0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_l = 1'b1;

    // Reset state
    rd_chk(12'h3A0);
    chk("rst_rd_cfg0", bus0.csr_rd_data, 32'h0);
    rd_chk(12'h3B0);
    chk("rst_rd_addr0", bus0.csr_rd_data, 32'h0);
    chk("rst_mode0", 32'(cfg_o0[0].mode), 32'(PMP_OFF));
    chk("rst_chg", 32'(chg0), 32'h0);

    // Basic cfg write and W-without-R legalisation
    wr(12'h3A0, 32'h0000_0F1F);
    chk("napot_chg", 32'(chg0), 32'h1);
    rd_chk(12'h3A0);
    chk("cfg0_lit_g0", bus0.csr_rd_data, 32'h0000_0F1F);
    chk("cfg0_lit_g2", bus2.csr_rd_data, 32'h0000_0F1F);
    wr(12'h3A0, 32'h0000_0002);
    rd_chk(12'h3A0);
    chk("w_no_r_lit", bus0.csr_rd_data, 32'h0);

    // Lock entry1 as TOR; dependent writes are ignored
    wr(12'h3A0, 32'h0000_8F00);
    wr(12'h3B0, 32'h0000_1000);
    chk("tor_lock_chg", 32'(chg0), 32'h0);
    wr(12'h3B1, 32'h0000_1000);
    wr(12'h3A0, 32'h0000_0F00);
    chk("unlock_chg", 32'(chg0), 32'h0);
    rd_chk(12'h3A0);
    chk("lock_lit", bus0.csr_rd_data, 32'h0000_8F00);
    rd_chk(12'h3B0);
    rd_chk(12'h3B1);
    state_chk();

    // Granularity read masking and NA4 legalisation
    mid_reset(32'hDEAD_BEEF);
    wr(12'h3A0, 32'h0000_0018);
    wr(12'h3B0, 32'h0000_1000);
    rd_chk(12'h3B0);
    chk("napot_g2_lit", bus2.csr_rd_data, 32'h0000_1001);
    chk("napot_g0_lit", bus0.csr_rd_data, 32'h0000_1000);
    wr(12'h3A0, 32'h0000_0008);
    rd_chk(12'h3B0);
    chk("tor_g2_lit", bus2.csr_rd_data, 32'h0000_1000);
    wr(12'h3B0, 32'h0000_1003);
    rd_chk(12'h3B0);
    chk("tor_mask_lit", bus2.csr_rd_data, 32'h0000_1000);
    chk("tor_g0_lit", bus0.csr_rd_data, 32'h0000_1003);
    wr(12'h3A0, 32'h0000_0010);
    rd_chk(12'h3A0);
    chk("na4_g2_lit", bus2.csr_rd_data, 32'h0000_0008);

    // Unimplemented entries
    wr(12'h3C5, 32'h0000_FFFF);
    chk("unimpl_chg", 32'(chg0), 32'h0);
    rd_chk(12'h3C5);
    chk("unimpl_hit", 32'(bus0.csr_rd_hit), 32'h1);
    wr(12'h3A4, 32'hFFFF_FFFF);
    rd_chk(12'h3A4);

    // Same-cycle read of the written CSR sees the old value
    set_rd(12'h3B0);
    drive(1'b1, 12'h3B0, 32'h0000_2220);
    #1;
    chk("rdwr_old_g0", bus0.csr_rd_data, model_read(0, 12'h3B0));
    wr(12'h3B0, 32'h0000_2220);
    rd_chk(12'h3B0);

    // Back-to-back changing writes
    wr(12'h3B3, 32'h0000_0033);
    wr(12'h3B4, 32'h0000_0044);
    wr(12'h3B4, 32'h0000_0044);

    // Randomised traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          a = 12'h3A0 + 12'($urandom_range(0, 5));
          for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 15) != 0) b[7] = 1'b0;
            v[8*k +: 8] = b;
          end
        end
        9: begin
          a = ($urandom_range(0, 1) == 0) ? 12'h300 + 12'($urandom_range(0, 159))
                                          : 12'h3F0 + 12'($urandom_range(0, 15));
          v = $urandom;
        end
        default: begin
          a = 12'h3B0 + 12'($urandom_range(0, 20));
          v = ($urandom_range(0, 7) == 0) ? maddr[0][0] : $urandom;
        end
      endcase
      wr(a, v);
      rd_chk(12'h3A0 + 12'($urandom_range(0, 84)));
      if (i % 100 == 50) begin
        state_chk();
        mid_reset($urandom);
      end
    end
    state_chk();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
